seq_match_ctrl: RTL
===================

# seq_match_ctrl

Run controller for a programmable serial pattern matcher. It generalises the fixed "101" sequence detectors to a configurable pattern of 1..MAX_LEN bits, in overlapping or non-overlapping mode. It sequences each detection run through configure, arm, run and completion, counts matches against a programmable limit, and throttles the serial bit source with a ready/valid handshake. It sits between a configuration master (register or CPU side) and a serial bit stream producer.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: width of match counter and match limit.
- LEN_W, $clog2(MAX_LEN)+1: localparam, width of length field.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  high only in IDLE.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is matched first, bit [0] last.
- cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN.
- cfg_limit  in  CNT_W  matches before auto-stop; 0 = unlimited.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cfg_err  out  1  one-cycle pulse: illegal config rejected.
- start  in  1  begin run (honoured only in ARMED).
- abort  in  1  cancel run (ARMED or RUN).
- bit_valid  in  1  serial bit offered.
- bit_in  in  1  serial bit.
- bit_ready  out  1  = (state==RUN) && !abort.
- match  out  1  one-cycle pulse per detected match.
- match_cnt  out  CNT_W  matches in current/last run.
- busy  out  1  high in ARMED or RUN.
- done  out  1  one-cycle pulse on limit reached.

## Operation
- States: IDLE, ARMED, RUN, DONE.
- IDLE: cfg_ready=1.
  - On cfg_valid with cfg_len in 1..MAX_LEN: latch pattern/len/limit/overlap and go to ARMED.
  - On cfg_valid with cfg_len 0 or >MAX_LEN: stay IDLE and pulse cfg_err next cycle.
  - start and abort are ignored.
- ARMED:
  - start: clear match_cnt, history and fill count; go to RUN.
  - abort: go to IDLE.
  - Both asserted: abort wins.
  - cfg_valid is ignored.
- RUN: each accepted bit (bit_valid && bit_ready) shifts into a MAX_LEN history register (new bit at LSB). The fill count increments, saturating at MAX_LEN.
- Match condition: fill+1 ≥ len and the low len bits of {history,bit_in} equal the low len bits of the pattern.
- On a match:
  - match pulses and match_cnt increments, saturating at all-ones.
  - Non-overlap mode: fill resets to 0.
  - Overlap mode: fill is kept.
- Limit reached (limit≠0 and incremented count == limit): go to DONE.
- abort in RUN: bit_ready is forced low that cycle (bit not consumed); go to IDLE with no done; match_cnt is retained.
- DONE: done=1 and bit_ready=0 for exactly one cycle, then IDLE. cfg is not accepted in DONE.
- Unused state encodings recover to IDLE.
- match_cnt holds its value in IDLE until the next start.

## Timing
- Reset values: state IDLE, cfg_ready=1, bit_ready=0, match=0, match_cnt=0, busy=0, done=0, cfg_err=0; history and fill are cleared.
- Reset has priority over all inputs, including mid-run; no done is produced.
- Config accepted at edge k: busy=1 from cycle k+1.
- start at edge k: bit_ready=1 from cycle k+1.
- Match latency: bit accepted at edge k gives match=1 and the updated match_cnt during cycle k+1 (registered).
- Limit hit on bit accepted at edge k:
  - cycle k+1: match=1, done=1, bit_ready=0.
  - cycle k+2: IDLE, cfg_ready=1.
- bit_valid gaps stall detection; history is unaffected.
- cfg_err is registered: illegal config at edge k gives a pulse in cycle k+1.

## Test plan
- Overlap, pattern 3'b101, len 3, limit 0; stream 1,0,1,0,1 → match after bits 3 and 5; match_cnt=2; no done.
- Non-overlap, same config and stream → match only after bit 3; match_cnt=1.
- Non-overlap, 101, limit 2; stream 1,0,1,1,0,1 → matches after bits 3 and 6.
  - done in the same cycle as the second match; bit_ready=0 that cycle; IDLE next cycle.
  - A 7th bit offered is not consumed.
- Overlap, pattern 8'hA5, len 8, limit 0; stream 0xA5 MSB-first with bit_valid low every other cycle → exactly one match, 1 cycle after the 8th accepted bit.
- cfg_len=0, then cfg_len=9 (MAX_LEN=8) → each rejected: cfg_err pulses once, state stays IDLE, busy=0.
- Abort mid-run after 2 matches, with bit_valid=1 on the abort cycle → bit not consumed, no done, match_cnt=2 retained, cfg_ready=1 next cycle.
- Reset during RUN → all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/seq_match_ctrl.sv
// ---------------------------------------------------------------------------
// seq_match_ctrl
//
// Run controller for a programmable serial pattern matcher. A configuration
// master loads a pattern of 1..MAX_LEN bits (matched MSB-first from bit
// [len-1] down to bit [0]), a match limit and an overlap mode. A run is then
// started, serial bits are consumed through a ready/valid handshake, matches
// are pulsed and counted, and the run ends automatically once the limit is
// reached (limit 0 = unlimited) or on abort.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   cfg_valid   configuration offered (accepted only in IDLE)
//   cfg_ready   high only in IDLE
//   cfg_pattern pattern bits, bit [cfg_len-1] matched first
//   cfg_len     pattern length, legal 1..MAX_LEN
//   cfg_limit   matches before auto-stop, 0 = unlimited
//   cfg_overlap 1 = overlapping matches allowed
//   cfg_err     one-cycle pulse after an illegal config is rejected
//   start       begin run (ARMED only)
//   abort       cancel run (ARMED or RUN), wins over start
//   bit_valid   serial bit offered
//   bit_in      serial bit
//   bit_ready   serial bit accepted this cycle when bit_valid is high
//   match       one-cycle pulse per detected match
//   match_cnt   matches in current/last run
//   busy        high in ARMED or RUN
//   done        one-cycle pulse when the match limit is reached
// ---------------------------------------------------------------------------
module seq_match_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_limit,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               bit_ready,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q,   pat_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic               ovl_q,   ovl_d;
    logic [MAX_LEN-1:0] hist_q,  hist_d;
    logic [LEN_W-1:0]   fill_q,  fill_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;

    logic               bit_acc;
    logic [MAX_LEN:0]   hist_ext;
    logic [MAX_LEN:0]   pat_ext;
    logic [MAX_LEN:0]   mask_ext;
    logic               fill_ok;
    logic               hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic               limit_hit;
    logic               cfg_legal;
    logic [LEN_W-1:0]   fill_inc;

    assign bit_ready = (state_q == S_RUN) && !abort;
    assign bit_acc   = bit_valid && bit_ready;

    // The incoming bit is compared together with the stored history so a
    // match is reported in the cycle right after the last pattern bit.
    // The extra top bit is always masked off since len never exceeds MAX_LEN.
    assign hist_ext  = {hist_q, bit_in};
    assign pat_ext   = {1'b0, pat_q};
    assign mask_ext  = ~({(MAX_LEN + 1){1'b1}} << len_q);
    assign fill_ok   = ({1'b0, fill_q} + 1'b1) >= {1'b0, len_q};
    assign hit       = fill_ok && ((hist_ext & mask_ext) == (pat_ext & mask_ext));

    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign limit_hit = (limit_q != '0) && (cnt_inc == limit_q);
    assign fill_inc  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        limit_d   = limit_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_legal) begin
                        pat_d   = cfg_pattern;
                        len_d   = cfg_len;
                        limit_d = cfg_limit;
                        ovl_d   = cfg_overlap;
                        state_d = S_ARMED;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    cnt_d   = '0;
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_acc) begin
                    hist_d = hist_ext[MAX_LEN-1:0];
                    fill_d = fill_inc;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        // Non-overlap: the next match must be built entirely
                        // from bits arriving after this one.
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                        if (limit_hit) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Configuration holding registers are only meaningful after a legal
    // config is accepted, so they carry no reset.
    always_ff @(posedge clk) begin
        pat_q   <= pat_d;
        len_q   <= len_d;
        limit_q <= limit_d;
        ovl_q   <= ovl_d;
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_ARMED) || (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule
